// File: rtl/clint_axil_responder.sv
// AXI4-Lite responder for the CLINT window: per-hart msip/mtimecmp, shared mtime
// advanced by a synchronised RTC tick, and registered timer/software interrupts.
module clint_axil_responder #(
    parameter int unsigned NrHarts   = 1,
    parameter int unsigned AddrWidth = 64,
    parameter logic [63:0] BaseAddr  = 64'h0200_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [63:0]          w_data_i,
    input  logic [7:0]           w_strb_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    output logic [63:0]          r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    input  logic                 rtc_i,
    output logic [NrHarts-1:0]   timer_irq_o,
    output logic [NrHarts-1:0]   ipi_o
);

    typedef enum logic [1:0] {DEC_MSIP, DEC_CMP, DEC_MTIME, DEC_ERR} dec_kind_e;
    typedef struct packed {
        dec_kind_e   kind;
        logic [16:0] idx;
    } dec_t;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    localparam logic [16:0] CmpLane   = 17'h00800;
    localparam logic [16:0] MtimeLane = 17'h017FF;
    localparam logic [16:0] MsipLanes = 17'((NrHarts + 1) / 2);
    localparam logic [16:0] NumHarts  = 17'(NrHarts);
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    // Lane index is the 8-byte word number within the window.
    function automatic dec_t decode(input logic [16:0] lane);
        dec_t d;
        d.kind = DEC_ERR;
        d.idx  = lane;
        if (lane < MsipLanes) begin
            d.kind = DEC_MSIP;
        end else if (lane >= CmpLane && (lane - CmpLane) < NumHarts) begin
            d.kind = DEC_CMP;
            d.idx  = lane - CmpLane;
        end else if (lane == MtimeLane) begin
            d.kind = DEC_MTIME;
        end
        return d;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
        logic [63:0] m;
        m = old;
        for (int unsigned b = 0; b < 8; b++) begin
            if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
        end
        return m;
    endfunction

    logic [63:0]              mtime;
    logic [NrHarts-1:0][63:0] mtimecmp;
    logic [NrHarts-1:0]       msip;
    logic                     rtc_q1, rtc_q2, rtc_q3;
    logic                     tick;

    wstate_e wstate_q, wstate_d;
    rstate_e rstate_q, rstate_d;
    logic    aw_fire, ar_fire;

    logic [AddrWidth-1:0] waddr_off, raddr_off;
    dec_t                 wdec, rdec;
    logic [63:0]          rdata;
    logic [1:0]           rresp;
    logic [NrHarts-1:0]   irq_d;
    logic                 unused_addr_bits;

    assign waddr_off = aw_addr_i - AddrWidth'(BaseAddr);
    assign raddr_off = ar_addr_i - AddrWidth'(BaseAddr);
    assign wdec      = decode(waddr_off[19:3]);
    assign rdec      = decode(raddr_off[19:3]);
    assign unused_addr_bits = ^{waddr_off[AddrWidth-1:20], waddr_off[2:0],
                                raddr_off[AddrWidth-1:20], raddr_off[2:0]};

    assign tick = rtc_q2 & ~rtc_q3;

    // Write FSM
    always_comb begin
        wstate_d = wstate_q;
        aw_fire  = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                aw_fire = aw_valid_i & w_valid_i;
                if (aw_fire) wstate_d = W_RESP;
            end
            W_RESP: if (b_ready_i) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read FSM
    always_comb begin
        rstate_d = rstate_q;
        ar_fire  = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                ar_fire = ar_valid_i;
                if (ar_fire) rstate_d = R_DATA;
            end
            R_DATA: if (r_ready_i) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    assign aw_ready_o = aw_fire & ~rst_i;
    assign w_ready_o  = aw_fire & ~rst_i;
    assign ar_ready_o = (rstate_q == R_IDLE) & ~rst_i;
    assign b_valid_o  = (wstate_q == W_RESP);
    assign r_valid_o  = (rstate_q == R_DATA);

    always_comb begin
        rdata = '0;
        rresp = RespOkay;
        unique case (rdec.kind)
            DEC_MSIP: begin
                for (int unsigned h = 0; h < NrHarts; h++) begin
                    if (17'(h / 2) == rdec.idx) begin
                        if (h % 2 == 0) rdata[0]  = msip[h];
                        else            rdata[32] = msip[h];
                    end
                end
            end
            DEC_CMP: begin
                for (int unsigned h = 0; h < NrHarts; h++) begin
                    if (17'(h) == rdec.idx) rdata = mtimecmp[h];
                end
            end
            DEC_MTIME: rdata = mtime;
            default:   rresp = RespSlvErr;
        endcase
    end

    always_comb begin
        irq_d = '0;
        for (int unsigned h = 0; h < NrHarts; h++) begin
            irq_d[h] = (mtime >= mtimecmp[h]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    // A software write to mtime is assigned after the tick increment, so it wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip     <= '0;
            rtc_q1   <= 1'b0;
            rtc_q2   <= 1'b0;
            rtc_q3   <= 1'b0;
            b_resp_o <= '0;
        end else begin
            rtc_q1 <= rtc_i;
            rtc_q2 <= rtc_q1;
            rtc_q3 <= rtc_q2;
            if (tick) mtime <= mtime + 64'd1;
            if (aw_fire) begin
                b_resp_o <= (wdec.kind == DEC_ERR) ? RespSlvErr : RespOkay;
                unique case (wdec.kind)
                    DEC_MSIP: begin
                        for (int unsigned h = 0; h < NrHarts; h++) begin
                            if (17'(h / 2) == wdec.idx) begin
                                if (h % 2 == 0) begin
                                    if (w_strb_i[0]) msip[h] <= w_data_i[0];
                                end else if (w_strb_i[4]) begin
                                    msip[h] <= w_data_i[32];
                                end
                            end
                        end
                    end
                    DEC_CMP: begin
                        for (int unsigned h = 0; h < NrHarts; h++) begin
                            if (17'(h) == wdec.idx)
                                mtimecmp[h] <= merge(mtimecmp[h], w_data_i, w_strb_i);
                        end
                    end
                    DEC_MTIME: mtime <= merge(mtime, w_data_i, w_strb_i);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_o <= '0;
            r_resp_o <= '0;
        end else if (ar_fire) begin
            r_data_o <= rdata;
            r_resp_o <= rresp;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_irq_o <= '0;
            ipi_o       <= '0;
        end else begin
            timer_irq_o <= irq_d;
            ipi_o       <= msip;
        end
    end

endmodule

// File: tb/tb_clint_axil_responder.sv
// Directed bench for clint_axil_responder: scoreboard queues hold expected B/R
// responses pushed at issue time and popped when the DUT responds.
module tb_clint_axil_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] aw_addr, ar_addr, w_data, r_data;
    logic [7:0]  w_strb;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready, rtc;
    logic [1:0]  b_resp, r_resp;
    logic [0:0]  timer_irq, ipi;

    int checks = 0;
    int errors = 0;

    logic [63:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic [1:0]  bq[$];

    clint_axil_responder #(.NrHarts(1), .AddrWidth(64), .BaseAddr(64'h0200_0000)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .rtc_i(rtc), .timer_irq_o(timer_irq), .ipi_o(ipi)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] resp);
        int n;
        bq.push_back(resp);
        aw_addr = addr; w_data = data; w_strb = strb;
        aw_valid = 1'b1; w_valid = 1'b1;
        #1;
        n = 0;
        while (!aw_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("aw_accept", 64'(aw_ready & w_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!b_valid && n < 20) begin @(negedge clk); n++; end
        check("b_valid", 64'(b_valid), 64'd1);
        check("b_resp", 64'(b_resp), 64'(bq.pop_front()));
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [63:0] addr, input logic [63:0] data,
                            input logic [1:0] resp);
        int n;
        rq_data.push_back(data);
        rq_resp.push_back(resp);
        ar_addr = addr; ar_valid = 1'b1;
        #1;
        n = 0;
        while (!ar_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("ar_accept", 64'(ar_ready), 64'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!r_valid && n < 20) begin @(negedge clk); n++; end
        check("r_valid", 64'(r_valid), 64'd1);
        check("r_data", r_data, rq_data.pop_front());
        check("r_resp", 64'(r_resp), 64'(rq_resp.pop_front()));
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic rtc_pulse();
        rtc = 1'b1;
        repeat (4) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rtc = 1'b0;
        aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
        aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ar_ready", 64'(ar_ready), 64'd0);
        check("reset_b_valid", 64'(b_valid), 64'd0);
        check("reset_r_valid", 64'(r_valid), 64'd0);
        check("reset_r_data", r_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_irq", 64'(timer_irq), 64'd0);
        check("reset_ipi", 64'(ipi), 64'd0);

        axi_read(64'h0200_BFF8, 64'd0, 2'b00);
        axi_read(64'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00);

        // Timer interrupt rises exactly one cycle after mtime reaches 0x10
        axi_write(64'h0200_4000, 64'h10, 8'hFF, 2'b00);
        check("irq_before_ticks", 64'(timer_irq), 64'd0);
        for (int i = 0; i < 15; i++) rtc_pulse();
        check("irq_at_15", 64'(timer_irq), 64'd0);
        rtc = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_same_cycle_as_16", 64'(timer_irq), 64'd0);
        @(negedge clk);
        check("irq_after_16", 64'(timer_irq), 64'd1);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        axi_read(64'h0200_BFF8, 64'h10, 2'b00);
        axi_write(64'h0200_4000, 64'h20, 8'hFF, 2'b00);
        check("irq_falls_cmp20", 64'(timer_irq), 64'd0);

        // msip: only bit 0 is stored
        axi_write(64'h0200_0000, 64'hFFFF_FFFF, 8'h0F, 2'b00);
        check("ipi_set", 64'(ipi), 64'd1);
        axi_read(64'h0200_0000, 64'h1, 2'b00);
        axi_write(64'h0200_0000, 64'h0, 8'h0F, 2'b00);
        check("ipi_clear", 64'(ipi), 64'd0);

        // mtime wrap
        axi_write(64'h0200_BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00);
        check("irq_mtime_max", 64'(timer_irq), 64'd1);
        rtc_pulse();
        check("irq_after_wrap", 64'(timer_irq), 64'd0);
        axi_read(64'h0200_BFF8, 64'd0, 2'b00);

        // Write to mtime on the same edge as a tick: written value stands
        rtc = 1'b1;
        repeat (2) @(negedge clk);
        axi_write(64'h0200_BFF8, 64'h1234, 8'hFF, 2'b00);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        axi_read(64'h0200_BFF8, 64'h1234, 2'b00);

        // Partial strobe on mtimecmp
        axi_write(64'h0200_4000, 64'hAAAA_BBBB_CCCC_DD00, 8'h02, 2'b00);
        axi_read(64'h0200_4000, 64'h0000_0000_0000_DD20, 2'b00);
        axi_write(64'h0200_4000, 64'h20, 8'hFF, 2'b00);

        // Unmapped offsets and out-of-range hart indices
        axi_write(64'h0200_8000, 64'h5, 8'hFF, 2'b10);
        axi_read(64'h0200_8000, 64'd0, 2'b10);
        axi_write(64'h0200_4008, 64'h5, 8'hFF, 2'b10);
        axi_read(64'h0200_4008, 64'd0, 2'b10);
        axi_read(64'h0200_0008, 64'd0, 2'b10);
        axi_read(64'h0200_4000, 64'h20, 2'b00);

        // B held while b_ready is low; a pending AW/W is not accepted
        aw_addr = 64'h0200_4000; w_data = 64'h30; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1;
        #1 check("stall_accept", 64'(aw_ready), 64'd1);
        @(posedge clk); #1;
        aw_addr = 64'h0200_8000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_b_valid", 64'(b_valid), 64'd1);
            check("stall_b_resp", 64'(b_resp), 64'd0);
            check("stall_aw_ready", 64'(aw_ready), 64'd0);
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        b_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
        check("stall_b_released", 64'(b_valid), 64'd0);
        axi_read(64'h0200_4000, 64'h30, 2'b00);

        // Asynchronous reset while both channels hold a response
        axi_write(64'h0200_0000, 64'h1, 8'h01, 2'b00);
        check("ipi_before_reset", 64'(ipi), 64'd1);
        aw_addr = 64'h0200_4000; w_data = 64'h55; w_strb = 8'hFF;
        aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = 64'h0200_BFF8; ar_valid = 1'b1;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_b_valid", 64'(b_valid), 64'd1);
        check("pre_reset_r_valid", 64'(r_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_b_valid", 64'(b_valid), 64'd0);
        check("async_r_valid", 64'(r_valid), 64'd0);
        check("async_ipi", 64'(ipi), 64'd0);
        check("async_r_data", r_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axi_read(64'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00);
        axi_read(64'h0200_BFF8, 64'd0, 2'b00);
        axi_read(64'h0200_0000, 64'd0, 2'b00);
        check("post_reset_irq", 64'(timer_irq), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
